// File: rtl/usbfs_host_sequencer_pkg.sv
// Shared definitions for the USB full-speed host sequencer.
// Holds the one-hot transaction type codes, the response status encodings,
// the sequencer state type and helpers that give the width and field offsets
// of a script entry for a given maximum packet size.
// Script entry layout, LSB up:
//   data[8*max_pkt], n_bytes[nb_w], endp[4], addr[7], type[3], exp_stall[1].
package usbfs_host_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitRsp,
    StGap,
    StDone,
    StError
  } seq_state_e;

  // One-hot {SETUP, OUT, IN}.
  localparam logic [2:0] TXNTYPE_SETUP = 3'b100;
  localparam logic [2:0] TXNTYPE_OUT   = 3'b010;
  localparam logic [2:0] TXNTYPE_IN    = 3'b001;

  localparam logic [1:0] RSP_ACK     = 2'd0;
  localparam logic [1:0] RSP_NAK     = 2'd1;
  localparam logic [1:0] RSP_STALL   = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  function automatic int unsigned nb_w(input int unsigned max_pkt);
    return $clog2(max_pkt) + 1;
  endfunction

  function automatic int unsigned entry_w(input int unsigned max_pkt);
    return 3 + 7 + 4 + nb_w(max_pkt) + 8 * max_pkt + 1;
  endfunction

  function automatic int unsigned off_data(input int unsigned max_pkt);
    return 0 * max_pkt;
  endfunction

  function automatic int unsigned off_nbytes(input int unsigned max_pkt);
    return 8 * max_pkt;
  endfunction

  function automatic int unsigned off_endp(input int unsigned max_pkt);
    return off_nbytes(max_pkt) + nb_w(max_pkt);
  endfunction

  function automatic int unsigned off_addr(input int unsigned max_pkt);
    return off_endp(max_pkt) + 4;
  endfunction

  function automatic int unsigned off_type(input int unsigned max_pkt);
    return off_addr(max_pkt) + 7;
  endfunction

  function automatic int unsigned off_exp_stall(input int unsigned max_pkt);
    return off_type(max_pkt) + 3;
  endfunction

endpackage

// File: rtl/usbfs_seq_script_mem.sv
// Script storage for the host sequencer: DEPTH x WIDTH RAM with one
// synchronous write port and one synchronous (registered) read port.
// No reset, so it maps onto block RAM and its contents survive a sequencer reset.
// Ports:
//   clk      clock
//   wr_en    write strobe
//   wr_idx   write index
//   wr_data  word written
//   rd_idx   read index, sampled every cycle
//   rd_data  word at rd_idx from the previous cycle
module usbfs_seq_script_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/usbfs_host_sequencer.sv
// USB full-speed host-transaction sequencer.
// Replays a loaded script of SETUP/OUT/IN descriptors onto the transactor's
// valid/ready interface one at a time, retries NAK/TIMEOUT responses after a
// programmable gap, checks expected STALLs and reports done / first failing entry.
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_wrValid/i_wrIdx/i_wrEntry       script write port (ignored while busy)
//   i_nEntries, i_start               run length and start pulse
//   o_txnValid, i_txnReady            transaction handshake
//   o_txnType/Addr/Endp/Data/_nBytes  transaction fields of the current entry
//   i_rspValid, i_rspStatus           response strobe and status
//   o_busy, o_done, o_error, o_errIdx run status
//   o_nTxns, o_nRetries               saturating statistics
module usbfs_host_sequencer
  import usbfs_host_sequencer_pkg::*;
#(
  parameter int unsigned MAX_PKT    = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned GAP_CYCLES = 4,
  localparam int unsigned NB_W      = nb_w(MAX_PKT),
  localparam int unsigned ENTRY_W   = entry_w(MAX_PKT),
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wrValid,
  input  logic [IDX_W-1:0]     i_wrIdx,
  input  logic [ENTRY_W-1:0]   i_wrEntry,
  input  logic [IDX_W:0]       i_nEntries,
  input  logic                 i_start,
  output logic                 o_txnValid,
  input  logic                 i_txnReady,
  output logic [2:0]           o_txnType,
  output logic [6:0]           o_txnAddr,
  output logic [3:0]           o_txnEndp,
  output logic [8*MAX_PKT-1:0] o_txnData,
  output logic [NB_W-1:0]      o_txnData_nBytes,
  input  logic                 i_rspValid,
  input  logic [1:0]           i_rspStatus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [IDX_W-1:0]     o_errIdx,
  output logic [31:0]          o_nTxns,
  output logic [15:0]          o_nRetries
);

  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [RETRY_W-1:0] RetryMax = RETRY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]   GapLast  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam int unsigned OFF_DATA  = off_data(MAX_PKT);
  localparam int unsigned OFF_NB    = off_nbytes(MAX_PKT);
  localparam int unsigned OFF_ENDP  = off_endp(MAX_PKT);
  localparam int unsigned OFF_ADDR  = off_addr(MAX_PKT);
  localparam int unsigned OFF_TYPE  = off_type(MAX_PKT);
  localparam int unsigned OFF_STALL = off_exp_stall(MAX_PKT);

  seq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   n_ent_q, n_ent_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic [IDX_W-1:0]   err_idx_q, err_idx_d;
  logic [31:0]        n_txns_q, n_txns_d;
  logic [15:0]        n_retries_q, n_retries_d;

  logic               busy;
  logic               advance;
  logic               fail;
  logic [ENTRY_W-1:0] entry;
  logic               exp_stall;

  assign busy      = (state_q == StIssue) || (state_q == StWaitRsp) || (state_q == StGap);
  assign exp_stall = entry[OFF_STALL];

  // Read address is the next-state index so entry[idx] is on the RAM output
  // in the same cycle the FSM enters ISSUE.
  usbfs_seq_script_mem #(
    .DEPTH(DEPTH),
    .WIDTH(ENTRY_W)
  ) u_script_mem (
    .clk    (i_clk),
    .wr_en  (i_wrValid && !busy),
    .wr_idx (i_wrIdx),
    .wr_data(i_wrEntry),
    .rd_idx (idx_d),
    .rd_data(entry)
  );

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      n_ent_q     <= '0;
      retry_q     <= '0;
      gap_q       <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_idx_q   <= '0;
      n_txns_q    <= '0;
      n_retries_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_ent_q     <= n_ent_d;
      retry_q     <= retry_d;
      gap_q       <= gap_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_idx_q   <= err_idx_d;
      n_txns_q    <= n_txns_d;
      n_retries_q <= n_retries_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_ent_d     = n_ent_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    done_d      = done_q;
    error_d     = error_q;
    err_idx_d   = err_idx_q;
    n_txns_d    = n_txns_q;
    n_retries_d = n_retries_q;
    advance     = 1'b0;
    fail        = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (i_start) begin
          idx_d       = '0;
          n_ent_d     = i_nEntries;
          retry_d     = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_idx_d   = '0;
          n_txns_d    = '0;
          n_retries_d = '0;
          if (i_nEntries == '0) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (i_txnReady) begin
          if (n_txns_q != '1) n_txns_d = n_txns_q + 32'd1;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (i_rspValid) begin
          unique case (i_rspStatus)
            RSP_ACK:   if (exp_stall) fail = 1'b1; else advance = 1'b1;
            RSP_STALL: if (exp_stall) advance = 1'b1; else fail = 1'b1;
            default: begin
              // NAK or TIMEOUT
              if (retry_q < RetryMax) begin
                retry_d = retry_q + RETRY_W'(1);
                if (n_retries_q != '1) n_retries_d = n_retries_q + 16'd1;
                gap_d   = '0;
                state_d = (GAP_CYCLES == 0) ? StIssue : StGap;
              end else begin
                fail = 1'b1;
              end
            end
          endcase
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIssue;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      idx_d   = idx_q + IDX_W'(1);
      retry_d = '0;
      if (({1'b0, idx_q} + CNT_W'(1)) == n_ent_q) begin
        done_d  = 1'b1;
        state_d = StDone;
      end else begin
        state_d = StIssue;
      end
    end

    if (fail) begin
      err_idx_d = idx_q;
      error_d   = 1'b1;
      state_d   = StError;
    end
  end

  // Outputs.
  always_comb begin
    o_txnValid       = (state_q == StIssue);
    o_txnType        = entry[OFF_TYPE +: 3];
    o_txnAddr        = entry[OFF_ADDR +: 7];
    o_txnEndp        = entry[OFF_ENDP +: 4];
    o_txnData_nBytes = entry[OFF_NB +: NB_W];
    o_txnData        = entry[OFF_DATA +: 8*MAX_PKT];
    o_busy           = busy;
    o_done           = done_q;
    o_error          = error_q;
    o_errIdx         = err_idx_q;
    o_nTxns          = n_txns_q;
    o_nRetries       = n_retries_q;
  end

endmodule

// File: tb/tb_usbfs_host_sequencer.sv
// Self-checking bench for usbfs_host_sequencer: acts as the host transactor,
// plays response plans derived from a per-entry outcome model and checks
// issued fields, retry gap timing and final status/statistics.
module tb_usbfs_host_sequencer;
  import usbfs_host_sequencer_pkg::*;

  localparam int unsigned MAX_PKT    = 8;
  localparam int unsigned DEPTH      = 32;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned GAP_CYCLES = 4;
  localparam int unsigned NB_W       = nb_w(MAX_PKT);
  localparam int unsigned ENTRY_W    = entry_w(MAX_PKT);
  localparam int unsigned IDX_W      = $clog2(DEPTH);
  localparam int unsigned DW         = 8 * MAX_PKT;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_valid = 1'b0;
  logic [IDX_W-1:0]   wr_idx = '0;
  logic [ENTRY_W-1:0] wr_entry = '0;
  logic [IDX_W:0]     n_entries = '0;
  logic               start = 1'b0;
  logic               txn_valid;
  logic               txn_ready = 1'b0;
  logic [2:0]         txn_type;
  logic [6:0]         txn_addr;
  logic [3:0]         txn_endp;
  logic [DW-1:0]      txn_data;
  logic [NB_W-1:0]    txn_nbytes;
  logic               rsp_valid = 1'b0;
  logic [1:0]         rsp_status = '0;
  logic               busy, done, error;
  logic [IDX_W-1:0]   err_idx;
  logic [31:0]        n_txns;
  logic [15:0]        n_retries;

  always #5 clk = ~clk;

  usbfs_host_sequencer #(
    .MAX_PKT   (MAX_PKT),
    .DEPTH     (DEPTH),
    .MAX_RETRY (MAX_RETRY),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_wrValid       (wr_valid),
    .i_wrIdx         (wr_idx),
    .i_wrEntry       (wr_entry),
    .i_nEntries      (n_entries),
    .i_start         (start),
    .o_txnValid      (txn_valid),
    .i_txnReady      (txn_ready),
    .o_txnType       (txn_type),
    .o_txnAddr       (txn_addr),
    .o_txnEndp       (txn_endp),
    .o_txnData       (txn_data),
    .o_txnData_nBytes(txn_nbytes),
    .i_rspValid      (rsp_valid),
    .i_rspStatus     (rsp_status),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error),
    .o_errIdx        (err_idx),
    .o_nTxns         (n_txns),
    .o_nRetries      (n_retries)
  );

  // Bench copy of the script, one array per field.
  logic [2:0]      t_type  [DEPTH];
  logic [6:0]      t_addr  [DEPTH];
  logic [3:0]      t_endp  [DEPTH];
  logic [NB_W-1:0] t_nb    [DEPTH];
  logic [DW-1:0]   t_data  [DEPTH];
  logic            t_stall [DEPTH];
  // Outcome plan per entry: number of NAK/TIMEOUTs, then the final status.
  int              k_fail  [DEPTH];
  logic [1:0]      fin     [DEPTH];

  logic [1:0] plan_q[$];
  int         idx_q[$];
  int         m_ntx, m_nret, m_erridx;
  logic       m_done, m_err;
  bit         nak_only = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] dut_fields();
    return 128'({txn_type, txn_addr, txn_endp, txn_nbytes, txn_data});
  endfunction

  function automatic logic [127:0] exp_fields(input int i);
    return 128'({t_type[i], t_addr[i], t_endp[i], t_nb[i], t_data[i]});
  endfunction

  function automatic logic [ENTRY_W-1:0] rand_entry();
    return ENTRY_W'({$urandom, $urandom, $urandom});
  endfunction

  task automatic set_entry(input int i, input logic [2:0] ty, input logic [6:0] ad,
                           input logic [3:0] ep, input logic [NB_W-1:0] nb,
                           input logic [DW-1:0] da, input logic st);
    t_type[i] = ty; t_addr[i] = ad; t_endp[i] = ep;
    t_nb[i] = nb; t_data[i] = da; t_stall[i] = st;
    k_fail[i] = 0;
    fin[i] = st ? RSP_STALL : RSP_ACK;
    wr_valid = 1'b1;
    wr_idx   = IDX_W'(i);
    wr_entry = {st, ty, ad, ep, nb, da};
    tick();
    wr_valid = 1'b0;
  endtask

  // Per-entry outcome model: entry i sees k_fail[i] NAK/TIMEOUTs (capped at
  // MAX_RETRY+1, which aborts) and then fin[i], which passes only when it
  // matches the STALL expectation.
  task automatic build_model(input int n);
    plan_q.delete();
    idx_q.delete();
    m_ntx = 0; m_nret = 0; m_erridx = 0;
    m_done = 1'b0; m_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      int tries = (k_fail[i] > int'(MAX_RETRY)) ? int'(MAX_RETRY) + 1 : k_fail[i];
      for (int j = 0; j < tries; j++) begin
        plan_q.push_back((nak_only || $urandom_range(0, 1) == 0) ? RSP_NAK : RSP_TIMEOUT);
        idx_q.push_back(i);
      end
      m_ntx  += tries;
      m_nret += (tries > int'(MAX_RETRY)) ? int'(MAX_RETRY) : tries;
      if (tries > int'(MAX_RETRY)) begin
        m_err = 1'b1; m_erridx = i;
        break;
      end
      plan_q.push_back(fin[i]);
      idx_q.push_back(i);
      m_ntx++;
      if ((fin[i] == RSP_STALL) != t_stall[i]) begin
        m_err = 1'b1; m_erridx = i;
        break;
      end
    end
    m_done = !m_err;
  endtask

  // Transactor: for every planned issue, check wait-since-response, fields,
  // field stability while stalled, then accept and answer.
  task automatic serve(input int dmin, input int dmax);
    bit prev_fail = 1'b0;
    for (int p = 0; p < plan_q.size(); p++) begin
      int w = 0;
      int d;
      int i = idx_q[p];
      while (!txn_valid && w < 60) begin
        tick();
        w++;
      end
      chk("issue_wait", 128'(w), 128'(prev_fail ? GAP_CYCLES : 0));
      if (!txn_valid) return;
      chk("fields", dut_fields(), exp_fields(i));
      d = $urandom_range(dmin, dmax);
      for (int c = 0; c < d; c++) begin
        // Writes while busy and responses outside WAIT_RSP must be ignored.
        wr_valid   = 1'b1;
        wr_idx     = IDX_W'($urandom);
        wr_entry   = rand_entry();
        rsp_valid  = ($urandom_range(0, 3) == 0);
        rsp_status = 2'($urandom);
        tick();
        chk("hold_valid", 128'(txn_valid), 128'(1));
        chk("hold_fields", dut_fields(), exp_fields(i));
      end
      wr_valid  = 1'b0;
      rsp_valid = 1'b0;
      txn_ready = 1'b1;
      tick();
      txn_ready = 1'b0;
      chk("valid_after_accept", 128'(txn_valid), 128'(0));
      repeat ($urandom_range(0, 3)) tick();
      rsp_valid  = 1'b1;
      rsp_status = plan_q[p];
      tick();
      rsp_valid  = 1'b0;
      prev_fail  = (plan_q[p] == RSP_NAK) || (plan_q[p] == RSP_TIMEOUT);
    end
  endtask

  task automatic check_end();
    chk("busy_end", 128'(busy), 128'(0));
    chk("valid_end", 128'(txn_valid), 128'(0));
    chk("done", 128'(done), 128'(m_done));
    chk("error", 128'(error), 128'(m_err));
    chk("err_idx", 128'(err_idx), 128'(m_erridx));
    chk("n_txns", 128'(n_txns), 128'(m_ntx));
    chk("n_retries", 128'(n_retries), 128'(m_nret));
  endtask

  task automatic run(input int n, input int dmin, input int dmax);
    build_model(n);
    n_entries = (IDX_W + 1)'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    serve(dmin, dmax);
    check_end();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 128'(txn_valid), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_error"}, 128'(error), 128'(0));
    chk({tag, "_err_idx"}, 128'(err_idx), 128'(0));
    chk({tag, "_n_txns"}, 128'(n_txns), 128'(0));
    chk({tag, "_n_retries"}, 128'(n_retries), 128'(0));
  endtask

  initial begin
    // Reset.
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // GET_DESCRIPTOR(DEVICE): SETUP, IN x3, zero-length OUT status, all ACK.
    set_entry(0, TXNTYPE_SETUP, 7'd0, 4'd0, NB_W'(8), 64'h0012000001000680, 1'b0);
    set_entry(1, TXNTYPE_IN, 7'd0, 4'd0, NB_W'(8), '0, 1'b0);
    set_entry(2, TXNTYPE_IN, 7'd0, 4'd0, NB_W'(8), '0, 1'b0);
    set_entry(3, TXNTYPE_IN, 7'd0, 4'd0, NB_W'(2), '0, 1'b0);
    set_entry(4, TXNTYPE_OUT, 7'd0, 4'd0, NB_W'(0), '0, 1'b0);
    run(5, 0, 2);
    chk("getdesc_n_txns", 128'(n_txns), 128'(5));
    chk("getdesc_done", 128'(done), 128'(1));

    // NAK, NAK, ACK on an IN entry.
    nak_only = 1'b1;
    set_entry(0, TXNTYPE_IN, 7'd5, 4'd1, NB_W'(8), '0, 1'b0);
    k_fail[0] = 2;
    run(1, 0, 1);
    chk("nak2_n_retries", 128'(n_retries), 128'(2));
    chk("nak2_n_txns", 128'(n_txns), 128'(3));

    // Four NAKs exhaust the retries.
    k_fail[0] = 4;
    run(1, 0, 1);
    chk("nak4_error", 128'(error), 128'(1));
    chk("nak4_err_idx", 128'(err_idx), 128'(0));
    chk("nak4_n_txns", 128'(n_txns), 128'(4));
    nak_only = 1'b0;

    // Zero entries: immediate done, clears the previous error.
    run(0, 0, 0);

    // Expected STALL on entry 3 passes, unexpected STALL on entry 4 aborts.
    for (int i = 0; i < 5; i++) begin
      set_entry(i, TXNTYPE_OUT, 7'(i + 1), 4'(i), NB_W'(i), {$urandom, $urandom}, i == 3);
    end
    fin[4] = RSP_STALL;
    run(5, 0, 1);
    chk("stall_err_idx", 128'(err_idx), 128'(4));
    chk("stall_error", 128'(error), 128'(1));

    // Ready held low for 20 cycles with writes attempted while busy, then re-run.
    set_entry(0, TXNTYPE_SETUP, 7'd9, 4'd0, NB_W'(8), 64'h0123456789abcdef, 1'b0);
    set_entry(1, TXNTYPE_IN, 7'd9, 4'd2, NB_W'(4), '0, 1'b0);
    run(2, 20, 20);
    run(2, 0, 2);

    // Asynchronous reset while waiting for a response.
    n_entries = (IDX_W + 1)'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_pre_valid", 128'(txn_valid), 128'(1));
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    chk("rst_pre_n_txns", 128'(n_txns), 128'(1));
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    #2 rst = 1'b0;
    tick();
    run(2, 0, 2);

    // Randomized scripts.
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        logic [2:0] ty;
        case ($urandom_range(0, 2))
          0:       ty = TXNTYPE_SETUP;
          1:       ty = TXNTYPE_OUT;
          default: ty = TXNTYPE_IN;
        endcase
        set_entry(i, ty, 7'($urandom), 4'($urandom), NB_W'($urandom_range(0, MAX_PKT)),
                  {$urandom, $urandom}, $urandom_range(0, 3) == 0);
        k_fail[i] = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0) fin[i] = t_stall[i] ? RSP_ACK : RSP_STALL;
      end
      run(n, 0, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
